// File: rtl/aes_pkg.sv
// Shared types and constants for the AES block packer.
// Block geometry, packer FSM states and the FIFO entry layout.
package aes_pkg;

    localparam int AES_BLK_BYTES = 16;
    localparam int AES_BLK_W     = 128;

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_PADBLK = 1'b1
    } pk_state_t;

    typedef struct packed {
        logic [AES_BLK_W-1:0] data;
        logic [4:0]           nbytes;
        logic                 last;
    } blk_ent_t;

    localparam int AES_ENT_W = $bits(blk_ent_t);

    // PKCS#7 pad value when the final byte sits at idx:
    // n = idx+1 message bytes, pad = 16-n = 15-idx.
    function automatic logic [7:0] pad_byte(
        input logic [3:0] idx
    );
        return {4'h0, ~idx};
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous FIFO holding completed packer blocks.
// Ports: clk, rst (sync, active-high), push/din, pop, full, empty, head.
module aes_blk_fifo #(
    parameter int W     = 134,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
    assign head  = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/aes_block_packer.sv
// Packs a valid/ready byte stream into 128-bit blocks for AES_top.
// Ports: clk, rst, in_byte/in_valid/in_last/in_ready,
//   blk_data/blk_nbytes/blk_last/blk_valid/blk_ready.
// Define AES_PKCS7_PAD_EN to PKCS#7-pad the final block.
module aes_block_packer
    import aes_pkg::*;
#(
    parameter int BLK_BYTES  = 16,
    parameter int OBUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [AES_BLK_W-1:0] blk_data,
    output logic [4:0]           blk_nbytes,
    output logic                 blk_last,
    output logic                 blk_valid,
    input  logic                 blk_ready
);

    localparam logic [3:0] LAST_IDX = 4'(BLK_BYTES - 1);

    pk_state_t            state;
    logic [3:0]           idx;
    logic [AES_BLK_W-1:0] asm_q;

    logic     accept;
    logic     blk_done;
    logic     push;
    logic     pop;
    logic     full;
    logic     empty;
    logic     out_en;
    blk_ent_t fill_ent;
    blk_ent_t pad_ent;
    blk_ent_t din;
    blk_ent_t head;

    assign in_ready = !rst && (state == ST_FILL) && !full;
    assign accept   = in_valid && in_ready;
    assign blk_done = accept &&
                      ((idx == LAST_IDX) || in_last);

    // Block as it will be pushed: stored bytes below idx,
    // the incoming byte at idx, fill above (only on in_last).
    always_comb begin
        fill_ent = '0;
        for (int k = 0; k < AES_BLK_BYTES; k++) begin
            if (4'(k) < idx) begin
                fill_ent.data[8*k +: 8] = asm_q[8*k +: 8];
            end else if (4'(k) == idx) begin
                fill_ent.data[8*k +: 8] = in_byte;
            end else begin
`ifdef AES_PKCS7_PAD_EN
                fill_ent.data[8*k +: 8] = pad_byte(idx);
`else
                fill_ent.data[8*k +: 8] = 8'h00;
`endif
            end
        end
        fill_ent.nbytes = {1'b0, idx} + 5'd1;
`ifdef AES_PKCS7_PAD_EN
        // A full final block needs a trailing pad block.
        fill_ent.last = in_last && (idx != LAST_IDX);
`else
        fill_ent.last = in_last;
`endif
    end

    always_comb begin
        pad_ent        = '0;
        pad_ent.data   = {AES_BLK_BYTES{8'h10}};
        pad_ent.nbytes = 5'd0;
        pad_ent.last   = 1'b1;
    end

    assign push = blk_done ||
                  ((state == ST_PADBLK) && !full);
    assign din  = (state == ST_PADBLK) ? pad_ent : fill_ent;
    assign pop  = blk_valid && blk_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FILL;
            idx   <= '0;
            asm_q <= '0;
        end else begin
            unique case (1'b1)
                (state == ST_FILL): begin
                    if (accept) begin
                        asm_q[8*idx +: 8] <= in_byte;
                        idx <= blk_done ? 4'd0 : idx + 4'd1;
`ifdef AES_PKCS7_PAD_EN
                        if (blk_done && in_last &&
                            (idx == LAST_IDX))
                            state <= ST_PADBLK;
`endif
                    end
                end
                (state == ST_PADBLK): begin
                    if (!full) state <= ST_FILL;
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    aes_blk_fifo #(
        .W     (AES_ENT_W),
        .DEPTH (OBUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Head fields read as zero while empty or in reset.
    assign out_en     = !rst && !empty;
    assign blk_valid  = out_en;
    assign blk_data   = out_en ? head.data : '0;
    assign blk_nbytes = out_en ? head.nbytes : 5'd0;
    assign blk_last   = out_en ? head.last : 1'b0;

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench for aes_block_packer.
// Honours AES_PKCS7_PAD_EN for expected values.
module tb_aes_block_packer;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [127:0] blk_data;
    logic [4:0]   blk_nbytes;
    logic         blk_last;
    logic         blk_valid;
    logic         blk_ready;

    int tests = 0;
    int fails = 0;
    bit rnd   = 1'b0;

    blk_ent_t   got[$];
    logic [8:0] acc[$];

    always #5 clk = ~clk;

    aes_block_packer #(
        .BLK_BYTES  (16),
        .OBUF_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .blk_data   (blk_data),
        .blk_nbytes (blk_nbytes),
        .blk_last   (blk_last),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready)
    );

    always @(negedge clk) begin
        if (!rst && blk_valid && blk_ready)
            got.push_back({blk_data, blk_nbytes, blk_last});
        if (in_valid && in_ready)
            acc.push_back({in_last, in_byte});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        int   n;
        logic ok;
        n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        in_last  = l;
        do begin
            @(negedge clk);
            ok = in_ready;
            cyc();
            if (rnd) blk_ready = 1'($urandom_range(0, 1));
            n++;
        end while (!ok && n < 300);
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (rnd && $urandom_range(0, 2) == 0) cyc();
    endtask

    task automatic drain(input string tag, input int want);
        int n;
        n = 0;
        blk_ready = 1'b1;
        while (got.size() < want && n < 300) begin
            cyc();
            n++;
        end
        repeat (4) cyc();
        chk({tag, "_count"}, got.size(), want);
    endtask

    task automatic chk_blk(input string tag, input int i,
                           input logic [127:0] d,
                           input int nb, input logic l);
        if (i < got.size()) begin
            chk({tag, "_data"}, got[i].data, d);
            chk({tag, "_nbytes"}, got[i].nbytes, nb);
            chk({tag, "_last"}, got[i].last, l);
        end else begin
            chk({tag, "_missing"}, 0, 1);
        end
    endtask

    function automatic logic [127:0] seq(input logic [7:0] s);
        logic [127:0] d;
        for (int k = 0; k < 16; k++)
            d[8*k +: 8] = s + 8'(k);
        return d;
    endfunction

    task automatic check_model();
        blk_ent_t     exp[$];
        blk_ent_t     e;
        logic [127:0] d;
        int           k;
        logic         l;
        d = '0;
        k = 0;
        foreach (acc[i]) begin
            l = acc[i][8];
            d[8*k +: 8] = acc[i][7:0];
            if (k == 15 || l) begin
`ifdef AES_PKCS7_PAD_EN
                if (l && k < 15)
                    for (int j = k + 1; j < 16; j++)
                        d[8*j +: 8] = 8'(15 - k);
                e = {d, 5'(k + 1), l && (k < 15)};
                exp.push_back(e);
                if (l && k == 15) begin
                    e = {{16{8'h10}}, 5'd0, 1'b1};
                    exp.push_back(e);
                end
`else
                e = {d, 5'(k + 1), l};
                exp.push_back(e);
`endif
                d = '0;
                k = 0;
            end else begin
                k++;
            end
        end
        drain("t6", exp.size());
        foreach (exp[i]) begin
            if (i < got.size())
                chk($sformatf("t6_blk%0d", i), got[i], exp[i]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", blk_valid, 0);
        chk("rst_data", blk_data, 0);
        chk("rst_nbytes", blk_nbytes, 0);
        chk("rst_last", blk_last, 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_valid", blk_valid, 0);

        // Test 1/2: full final block
        got.delete();
        blk_ready = 1'b1;
        for (int i = 0; i < 15; i++)
            send(8'hF1 + 8'(i), 1'b0);
        send(8'h00, 1'b1);
        chk("t1_latency_valid", blk_valid, 1);
`ifdef AES_PKCS7_PAD_EN
        drain("t2", 2);
        chk_blk("t2_b0", 0,
            128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1, 16, 0);
        chk_blk("t2_pad", 1, {16{8'h10}}, 0, 1);
`else
        drain("t1", 1);
        chk_blk("t1_b0", 0,
            128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1, 16, 1);
`endif

        // Test 3: short final block
        got.delete();
        for (int i = 1; i < 5; i++)
            send(8'(i), 1'b0);
        send(8'h05, 1'b1);
        drain("t3", 1);
`ifdef AES_PKCS7_PAD_EN
        chk_blk("t3_b0", 0,
            128'h0B0B0B0B0B0B0B0B0B0B0B0504030201, 5, 1);
`else
        chk_blk("t3_b0", 0, 128'h0504030201, 5, 1);
`endif

        // Test 4: backpressure with full FIFO
        got.delete();
        blk_ready = 1'b0;
        for (int i = 1; i <= 32; i++)
            send(8'(i), 1'b0);
        in_byte  = 8'd33;
        in_valid = 1'b1;
        repeat (5) cyc();
        @(negedge clk);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_valid", blk_valid, 1);
        chk("t4_idx", dut.idx, 0);
        chk("t4_head", blk_data, seq(8'd1));
        chk("t4_none_popped", got.size(), 0);
        cyc();
        blk_ready = 1'b1;
        for (int i = 33; i <= 48; i++)
            send(8'(i), 1'b0);
        drain("t4", 3);
        chk_blk("t4_b0", 0, seq(8'd1), 16, 0);
        chk_blk("t4_b1", 1, seq(8'd17), 16, 0);
        chk_blk("t4_b2", 2, seq(8'd33), 16, 0);

        // Test 5: reset mid-block with a block queued
        got.delete();
        blk_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            send(8'h60 + 8'(i), 1'b0);
        for (int i = 0; i < 7; i++)
            send(8'h50 + 8'(i), 1'b0);
        @(negedge clk);
        chk("t5_pre_valid", blk_valid, 1);
        cyc();
        rst = 1'b1;
        #1;
        chk("t5_rst_valid_async", blk_valid, 0);
        cyc();
        @(negedge clk);
        chk("t5_rst_valid", blk_valid, 0);
        chk("t5_rst_data", blk_data, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("t5_post_valid", blk_valid, 0);
        blk_ready = 1'b1;
        for (int i = 0; i < 15; i++)
            send(8'h20 + 8'(i), 1'b0);
        send(8'h2F, 1'b1);
`ifdef AES_PKCS7_PAD_EN
        drain("t5", 2);
        chk_blk("t5_b0", 0, seq(8'h20), 16, 0);
        chk_blk("t5_pad", 1, {16{8'h10}}, 0, 1);
`else
        drain("t5", 1);
        chk_blk("t5_b0", 0, seq(8'h20), 16, 1);
`endif

        // Test 6: random throttling against a model
        got.delete();
        acc.delete();
        rnd = 1'b1;
        for (int i = 0; i < 1000; i++)
            send(8'($urandom), (i == 999) ||
                 ($urandom_range(0, 9) == 0));
        rnd = 1'b0;
        chk("t6_accepted", acc.size(), 1000);
        check_model();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
